mux_nx1_rr: RTL and testbench

//  Registered N:1 data multiplexer; parametrised successor of the 2:1 / 4:1 combinational muxes.

---
 rtl/mux_pkg.sv | 12 +
 rtl/mux_nx1_rr_arbiter.sv | 28 ++
 rtl/mux_nx1_rr.sv | 75 +++++++
 tb/tb_mux_nx1_rr.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode and state encodings for mux_nx1_rr
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/mux_nx1_rr_arbiter.sv
// rtl/mux_nx1_rr_arbiter.sv - combinational rotate-priority search (module rr_arbiter)
module rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  int j;

  // Walk from ptr upward with wrap; the first requester found wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!gnt_valid && req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// rtl/mux_nx1_rr.sv - registered N:1 mux with manual/round-robin select; optional parity via MUX_PARITY_EN
module mux_nx1_rr
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N*W-1:0]   d,
  input  logic [N-1:0]     d_valid,
  output logic [N-1:0]     d_ready,
  input  logic             y_ready,
  output logic [W-1:0]     y,
  output logic             y_valid
`ifdef MUX_PARITY_EN
  ,
  output logic             y_par
`endif
);

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_valid;
  logic             man_valid;
  logic [SEL_W-1:0] g;
  logic             grant_valid;
  logic             can_load;
  logic             xfer;
  logic [W-1:0]     g_data;

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req       (d_valid),
    .ptr       (rr_ptr),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  // Out-of-range sel (non-power-of-2 N) never grants.
  assign man_valid   = (int'(sel) < N) && d_valid[sel];
  assign g           = (mode == MODE_RR) ? rr_idx : sel;
  assign grant_valid = (mode == MODE_RR) ? rr_valid : man_valid;

  assign y_valid  = (state == ST_FULL);
  assign can_load = !y_valid || y_ready;
  assign d_ready  = (rst_n && grant_valid && can_load) ? (N'(1) << g) : '0;
  assign xfer     = |(d_valid & d_ready);
  assign g_data   = d[int'(g)*W +: W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      y      <= '0;
      rr_ptr <= '0;
`ifdef MUX_PARITY_EN
      y_par  <= 1'b0;
`endif
    end else if (xfer) begin
      state <= ST_FULL;
      y     <= g_data;
`ifdef MUX_PARITY_EN
      y_par <= ^g_data;
`endif
      if (mode == MODE_RR)
        rr_ptr <= SEL_W'((int'(g) + 1) % N);
    end else if (y_ready) begin
      state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb/tb_mux_nx1_rr.sv - randomized + directed bench for mux_nx1_rr against a behavioural model
module tb_mux_nx1_rr;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [1:0]     sel;
  logic [N*W-1:0] d;
  logic [N-1:0]   d_valid;
  logic [N-1:0]   d_ready;
  logic           y_ready;
  logic [W-1:0]   y;
  logic           y_valid;
`ifdef MUX_PARITY_EN
  logic           y_par;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  int         m_ptr;
  logic [7:0] m_y;
  logic       m_valid;
  logic       m_par;

  always #5 clk = ~clk;

  mux_nx1_rr #(.N(N), .W(W)) dut (
`ifdef MUX_PARITY_EN
    .y_par   (y_par),
`endif
    .clk     (clk),
    .rst_n   (rst_n),
    .mode    (mode),
    .sel     (sel),
    .d       (d),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .y_ready (y_ready),
    .y       (y),
    .y_valid (y_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_channel(input logic m, input int s, input logic [3:0] dv, input int ptr);
    if (!m) return (s < N && dv[s]) ? s : -1;
    for (int k = 0; k < N; k++)
      if (dv[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // One clock: drive at negedge, check outputs against the model, then advance the model.
  task automatic cycle(input logic m, input logic [1:0] s, input logic [31:0] data,
                       input logic [3:0] dv, input logic yr, input logic rn, input bit chk_out);
    int         gi;
    logic [3:0] exp_rdy;
    @(negedge clk);
    mode = m; sel = s; d = data; d_valid = dv; y_ready = yr; rst_n = rn;
    #1;
    gi = pick_channel(m, int'(s), dv, m_ptr);
    exp_rdy = (rn && gi >= 0 && (!m_valid || yr)) ? 4'(1 << gi) : 4'b0;
    check("d_ready", 32'(d_ready), 32'(exp_rdy));
    if (chk_out) begin
      check("y", 32'(y), 32'(m_y));
      check("y_valid", 32'(y_valid), 32'(m_valid));
`ifdef MUX_PARITY_EN
      check("y_par", 32'(y_par), 32'(m_par));
`endif
    end
    @(posedge clk);
    if (!rn) begin
      m_y = 8'h0; m_valid = 1'b0; m_ptr = 0; m_par = 1'b0;
    end else if (exp_rdy != 0) begin
      m_y = data[gi*8 +: 8];
      m_par = ^m_y;
      m_valid = 1'b1;
      if (m) m_ptr = (gi + 1) % N;
    end else if (yr) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [31:0] inc;
    logic [7:0]  seq [5];
    inc = 32'h13121110;
    seq[0] = 8'h10; seq[1] = 8'h11; seq[2] = 8'h12; seq[3] = 8'h13; seq[4] = 8'h10;
    m_ptr = 0; m_y = 8'h0; m_valid = 1'b0; m_par = 1'b0;
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; d = '0; d_valid = '0; y_ready = 1'b0;

    // T1: reset held with all channels valid
    cycle(1'b0, 2'd0, 32'h44332211, 4'b1111, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 2'd0, 32'h44332211, 4'b1111, 1'b1, 1'b0, 1'b1);
    check("t1_y", 32'(y), 32'h0);
    check("t1_valid", 32'(y_valid), 32'h0);
    cycle(1'b0, 2'd0, 32'h44332211, 4'b1111, 1'b1, 1'b1, 1'b1);
    check("t1_first_load", 32'(y), 32'h11);

    // T2: manual select of channel 2
    cycle(1'b0, 2'd2, 32'h00A50000, 4'b0100, 1'b1, 1'b1, 1'b1);
    check("t2_y", 32'(y), 32'hA5);
    check("t2_valid", 32'(y_valid), 32'h1);

    // T3: backpressure holds the word
    cycle(1'b0, 2'd2, 32'h003C0000, 4'b0100, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 2'd2, 32'h00770000, 4'b0100, 1'b0, 1'b1, 1'b1);
      check("t3_hold", 32'(y), 32'h3C);
    end
    cycle(1'b0, 2'd2, 32'h00770000, 4'b0100, 1'b1, 1'b1, 1'b1);
    check("t3_reload", 32'(y), 32'h77);

    // T4: round-robin over all channels from a fresh pointer
    cycle(1'b1, 2'd0, inc, 4'b0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 2'd0, inc, 4'b1111, 1'b1, 1'b1, 1'b1);
      check("t4_seq", 32'(y), 32'(seq[i]));
    end

    // T5: rr skip with idle gaps (pointer now 1)
    cycle(1'b1, 2'd0, 32'hD3000000 | 32'h000000D0, 4'b1001, 1'b1, 1'b1, 1'b1);
    check("t5_g3", 32'(y), 32'hD3);
    cycle(1'b1, 2'd0, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 2'd0, 32'hD30000D0, 4'b1001, 1'b1, 1'b1, 1'b1);
    check("t5_g0", 32'(y), 32'hD0);
    cycle(1'b1, 2'd0, 32'hE30000E0, 4'b1001, 1'b1, 1'b1, 1'b1);
    check("t5_g3b", 32'(y), 32'hE3);

    // T6: replace while full, then drain
    cycle(1'b0, 2'd0, 32'h000000F1, 4'b0001, 1'b1, 1'b1, 1'b1);
    check("t6_replace", 32'(y), 32'hF1);
    check("t6_valid", 32'(y_valid), 32'h1);
    cycle(1'b0, 2'd0, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b1);
    check("t6_empty", 32'(y_valid), 32'h0);

    // Randomized traffic, including mode switches and occasional reset
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 2'($urandom), $urandom, 4'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) != 0), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
